// File: rtl/axis_keep_packer_pkg.sv
// Shared types and helpers for the axis_keep_packer block.
// Helpers are written for beats of up to MAX_WORDS words.
package axis_keep_packer_pkg;

  localparam int MAX_WORDS = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Number of set bits in a (zero-extended) keep vector.
  function automatic logic [5:0] popcount(input logic [MAX_WORDS-1:0] keep);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      c = c + {5'd0, keep[i]};
    end
    return c;
  endfunction

  // Contiguous keep of k words starting at word 0: (1<<k)-1.
  function automatic logic [MAX_WORDS-1:0] keep_mask(input logic [5:0] k);
    logic [MAX_WORDS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      if (6'(i) < k) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_keep_compress.sv
// Combinational compaction of one beat: kept words are moved down to
// word 0 upwards in their original order, unused upper words are zero.
// Also reports how many words were kept.
module axis_keep_compress
  import axis_keep_packer_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int WORDS  = 4
) (
  input  logic [WORD_W*WORDS-1:0]    data,
  input  logic [WORDS-1:0]           keep,
  output logic [WORD_W*WORDS-1:0]    dense,
  output logic [$clog2(WORDS+1)-1:0] n
);

  localparam int NW = $clog2(WORDS+1);

  assign n = NW'(popcount(MAX_WORDS'(keep)));

  // Each kept word lands at the running count of kept words below it.
  always_comb begin
    int pos;
    dense = '0;
    pos   = 0;
    for (int i = 0; i < WORDS; i++) begin
      if (keep[i]) begin
        dense[pos*WORD_W +: WORD_W] = data[i*WORD_W +: WORD_W];
        pos = pos + 1;
      end
    end
  end

endmodule

// File: rtl/axis_keep_packer.sv
// axis_keep_packer: turns an AXI-Stream with arbitrary tkeep holes into a
// dense stream. Kept words are packed into full beats; only the tlast beat
// may be partial, with tkeep contiguous from word 0.
//
// Valid/ready: a transfer happens on a clock edge where tvalid && tready are
// both high; a producer holds tvalid and its payload until that edge, and the
// ready side may change freely.
//
// Optional feature: define AXIS_KEEP_PACKER_STATS_EN to get the drop_cnt
// port, a 16-bit saturating count of dropped empty packets.
module axis_keep_packer
  import axis_keep_packer_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int WORDS  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WORD_W*WORDS-1:0] s_axis_tdata,
  input  logic [WORDS-1:0]        s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [WORD_W*WORDS-1:0] m_axis_tdata,
  output logic [WORDS-1:0]        m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
`ifdef AXIS_KEEP_PACKER_STATS_EN
  ,
  output logic [15:0]             drop_cnt
`endif
);

  localparam int NW = $clog2(WORDS+1);
  localparam int CW = $clog2(2*WORDS);
  localparam int RW = 2*WORDS-1;

  state_t                       state;
  state_t                       state_next;
  logic                         alive;
  logic [CW-1:0]                cnt;
  logic [RW-1:0][WORD_W-1:0]    res_q;
  logic [RW-1:0][WORD_W-1:0]    merged;
  logic [RW-1:0][WORD_W-1:0]    shifted;
  logic [WORD_W*WORDS-1:0]      dense;
  logic [NW-1:0]                n;
  logic [CW-1:0]                total;
  logic                         slot_free;
  logic                         accept;
  logic                         full;
  logic                         over;

  axis_keep_compress #(
    .WORD_W(WORD_W),
    .WORDS (WORDS)
  ) u_compress (
    .data (s_axis_tdata),
    .keep (s_axis_tkeep),
    .dense(dense),
    .n    (n)
  );

  assign slot_free = !m_axis_tvalid || m_axis_tready;
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign total     = cnt + CW'(n);
  assign full      = total >= CW'(WORDS);
  assign over      = total >  CW'(WORDS);

  // Residue words below cnt followed by the compacted input beat.
  always_comb begin
    merged = '0;
    for (int j = 0; j < RW; j++) begin
      if (j < int'(cnt)) begin
        merged[j] = res_q[j];
      end else if ((j - int'(cnt)) < WORDS) begin
        merged[j] = dense[(j - int'(cnt))*WORD_W +: WORD_W];
      end
    end
  end

  // Words left over after one full beat is taken from the merge.
  always_comb begin
    shifted = '0;
    for (int j = 0; j + WORDS < RW; j++) begin
      shifted[j] = merged[j + WORDS];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // FSM next state: an overflowing tlast beat needs one extra cycle to flush.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (accept && s_axis_tlast && over) state_next = FLUSH;
      FLUSH:   if (slot_free) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // FSM output: input is taken only in RUN, once out of reset, with a free slot.
  always_comb begin
    s_axis_tready = alive && (state == RUN) && slot_free;
  end

  // Residue buffer, word count and the registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive         <= 1'b0;
      cnt           <= '0;
      res_q         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (slot_free) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tdata  <= '0;
        m_axis_tkeep  <= '0;
        m_axis_tlast  <= 1'b0;
        if (state == FLUSH) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= res_q[WORDS-1:0];
          m_axis_tkeep  <= WORDS'(keep_mask(6'(cnt)));
          m_axis_tlast  <= 1'b1;
          cnt           <= '0;
          res_q         <= '0;
        end else if (accept) begin
          if (over || (full && !s_axis_tlast)) begin
            // A full beat leaves; the remainder stays buffered.
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= merged[WORDS-1:0];
            m_axis_tkeep  <= '1;
            cnt           <= total - CW'(WORDS);
            res_q         <= shifted;
          end else if (s_axis_tlast) begin
            // Whole packet tail fits in one beat; an empty tail is dropped.
            if (total != '0) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= merged[WORDS-1:0];
              m_axis_tkeep  <= WORDS'(keep_mask(6'(total)));
              m_axis_tlast  <= 1'b1;
            end
            cnt   <= '0;
            res_q <= '0;
          end else begin
            cnt   <= total;
            res_q <= merged;
          end
        end
      end
    end
  end

`ifdef AXIS_KEEP_PACKER_STATS_EN
  logic drop_evt;
  assign drop_evt = accept && s_axis_tlast && (total == '0);

  // Saturating count of packets that carried no kept words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_evt && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_keep_packer.sv
// Bench for axis_keep_packer (WORD_W=8, WORDS=4). A queue-based packet model
// predicts every output beat; directed packets pin the model with literals.
`timescale 1ns/1ps
module tb_axis_keep_packer;

  localparam int WORD_W = 8;
  localparam int WORDS  = 4;
  localparam int DW     = WORD_W*WORDS;
  localparam int EW     = DW + WORDS + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]    s_axis_tdata;
  logic [WORDS-1:0] s_axis_tkeep;
  logic             s_axis_tlast;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic [WORDS-1:0] m_axis_tkeep;
  logic             m_axis_tlast;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
`ifdef AXIS_KEEP_PACKER_STATS_EN
  logic [15:0]      drop_cnt;
`endif

  axis_keep_packer #(.WORD_W(WORD_W), .WORDS(WORDS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
`ifdef AXIS_KEEP_PACKER_STATS_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0]     exp_q[$];
  logic [EW-1:0]     got_q[$];
  logic [WORD_W-1:0] cur_q[$];
  int drops = 0;
  bit rand_ready = 1'b0;
  bit hold = 1'b0;
  logic [EW-1:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Take n words from the pending packet as one expected output beat.
  task automatic push_chunk(input int n, input logic last);
    logic [DW-1:0]    d;
    logic [WORDS-1:0] k;
    d = '0;
    k = '0;
    for (int i = 0; i < n; i++) begin
      d[i*WORD_W +: WORD_W] = cur_q.pop_front();
      k[i] = 1'b1;
    end
    exp_q.push_back({d, k, last});
  endtask

  // Packet-level model: kept words queue up, full beats leave as soon as they
  // exist, the packet end closes out the rest (an empty end is a drop).
  task automatic model_accept(input logic [DW-1:0] d, input logic [WORDS-1:0] k, input logic l);
    for (int i = 0; i < WORDS; i++) begin
      if (k[i]) cur_q.push_back(d[i*WORD_W +: WORD_W]);
    end
    if (!l) begin
      while (cur_q.size() >= WORDS) push_chunk(WORDS, 1'b0);
    end else if (cur_q.size() == 0) begin
      drops++;
    end else begin
      while (cur_q.size() > WORDS) push_chunk(WORDS, 1'b0);
      push_chunk(cur_q.size(), 1'b1);
    end
  endtask

  // Compare process: input accepts feed the model, output transfers are checked.
  always @(negedge clk) begin
    logic [EW-1:0] beat;
    beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    if (!rst_n) begin
      cur_q.delete();
      hold = 1'b0;
    end else begin
      if (s_axis_tvalid && s_axis_tready) model_accept(s_axis_tdata, s_axis_tkeep, s_axis_tlast);
      if (hold) check("hold_stable", 64'({m_axis_tvalid, beat}), 64'({1'b1, held}));
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back(beat);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", beat);
        end else begin
          check("out_beat", 64'(beat), 64'(exp_q.pop_front()));
        end
      end
      hold = m_axis_tvalid && !m_axis_tready;
      held = beat;
    end
  end

  // Output ready: always 1 in directed phases, random bubbles otherwise.
  always @(posedge clk) begin
    #1;
    m_axis_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns after the beat is accepted.
  task automatic send_beat(input logic [DW-1:0] d, input logic [WORDS-1:0] k,
                           input logic l, output int waited);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!s_axis_tready && waited <= 500) begin
      waited++;
      @(negedge clk);
    end
    if (waited > 500) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=%0d required=<=500", waited);
      @(posedge clk);
    end else begin
      @(posedge clk);
    end
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_packet(input int words);
    int kept;
    int room;
    int c;
    int w;
    logic [WORDS-1:0] k;
    logic [DW-1:0] d;
    kept = 0;
    while (kept < words) begin
      k = 4'($urandom_range(0, 15));
      d = $urandom();
      room = words - kept;
      c = 0;
      for (int i = 0; i < WORDS; i++) begin
        if (k[i]) begin
          if (c < room) c++;
          else k[i] = 1'b0;
        end
      end
      kept += c;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      send_beat(d, k, (kept == words), w);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int base;
    int drops_before;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;

    // Reset state.
    #12;
    check("reset_outputs",
          64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_axis_tready}), 64'd0);
    #10 rst_n = 1'b1;
    #1;
    check("ready_before_edge", 64'(s_axis_tready), 64'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 64'(s_axis_tready), 64'd1);

    // Dense 10-word packet.
    base = got_q.size();
    send_beat(32'h03020100, 4'hf, 1'b0, w);
    send_beat(32'h07060504, 4'hf, 1'b0, w);
    send_beat(32'h00000908, 4'h3, 1'b1, w);
    drain();
    check("dense_count", 64'(got_q.size() - base), 64'd3);
    if (got_q.size() - base == 3) begin
      check("dense_b0", 64'(got_q[base]),   64'({32'h03020100, 4'hf, 1'b0}));
      check("dense_b1", 64'(got_q[base+1]), 64'({32'h07060504, 4'hf, 1'b0}));
      check("dense_b2", 64'(got_q[base+2]), 64'({32'h00000908, 4'h3, 1'b1}));
    end

    // Holes.
    base = got_q.size();
    send_beat(32'h03020100, 4'h5, 1'b0, w);
    send_beat(32'h07060504, 4'hf, 1'b1, w);
    drain();
    check("holes_count", 64'(got_q.size() - base), 64'd2);
    if (got_q.size() - base == 2) begin
      check("holes_b0", 64'(got_q[base]),   64'({32'h05040200, 4'hf, 1'b0}));
      check("holes_b1", 64'(got_q[base+1]), 64'({32'h00000706, 4'h3, 1'b1}));
    end

    // Overflowing tlast beat: full beat, then one-word flush, one input bubble.
    base = got_q.size();
    send_beat(32'h03020100, 4'h7, 1'b0, w);
    send_beat(32'h07060504, 4'h3, 1'b1, w);
    send_beat(32'h0b0a0908, 4'hf, 1'b1, w);
    check("flush_bubble", 64'(w), 64'd1);
    drain();
    check("flush_count", 64'(got_q.size() - base), 64'd3);
    if (got_q.size() - base == 3) begin
      check("flush_b0", 64'(got_q[base]),   64'({32'h04020100, 4'hf, 1'b0}));
      check("flush_b1", 64'(got_q[base+1]), 64'({32'h00000005, 4'h1, 1'b1}));
      check("flush_b2", 64'(got_q[base+2]), 64'({32'h0b0a0908, 4'hf, 1'b1}));
    end

    // Empty packet, then a packet with an empty mid beat.
    base = got_q.size();
    drops_before = drops;
    send_beat(32'hdeadbeef, 4'h0, 1'b1, w);
    drain();
    check("empty_no_output", 64'(got_q.size() - base), 64'd0);
    check("empty_model_drop", 64'(drops - drops_before), 64'd1);
`ifdef AXIS_KEEP_PACKER_STATS_EN
    check("drop_cnt_first", 64'(drop_cnt), 64'd1);
`endif
    send_beat(32'hcafef00d, 4'h0, 1'b0, w);
    send_beat(32'h44332211, 4'h3, 1'b1, w);
    drain();
    check("after_empty_count", 64'(got_q.size() - base), 64'd1);
    if (got_q.size() - base == 1) begin
      check("after_empty_b0", 64'(got_q[base]), 64'({32'h00002211, 4'h3, 1'b1}));
    end

    // Random packets with holes, input gaps and output backpressure.
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      send_packet($urandom_range(1, 100));
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset with two words buffered.
    send_beat(32'h0c0b0a09, 4'h3, 1'b0, w);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midpkt_reset_outputs",
          64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_axis_tready}), 64'd0);
    exp_q.delete();
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = got_q.size();
    send_beat(32'h0d0c0b0a, 4'hf, 1'b1, w);
    drain();
    check("post_reset_count", 64'(got_q.size() - base), 64'd1);
    if (got_q.size() - base == 1) begin
      check("post_reset_b0", 64'(got_q[base]), 64'({32'h0d0c0b0a, 4'hf, 1'b1}));
    end
`ifdef AXIS_KEEP_PACKER_STATS_EN
    check("drop_cnt_after_reset", 64'(drop_cnt), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
